// File: rtl/dmx_pwm_dimmer.sv
// DMX512 receiver feeding PWM_CHANNELS gamma-corrected 16-bit PWM outputs.
// The raw line is also repeated one clock later on dmx_tx.
module dmx_pwm_dimmer #(
  parameter int  PWM_CHANNELS = 8,
  parameter int  BIT_CLKS     = 96,
  parameter int  BREAK_CLKS   = 2112,
  parameter int  MAB_CLKS     = 192,
  parameter real GAMMA        = 1.8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    dmx_rx,
  output logic                    dmx_tx,
  output logic [PWM_CHANNELS-1:0] pwm_n,
  output logic                    oe
);

  localparam int LW = $clog2(BREAK_CLKS);
  localparam int MW = $clog2(MAB_CLKS + 1);
  localparam int BW = $clog2(BIT_CLKS);

  localparam logic [BW-1:0] HALF_BIT   = BW'(BIT_CLKS / 2 - 1);
  localparam logic [BW-1:0] FULL_BIT   = BW'(BIT_CLKS - 1);
  localparam logic [LW-1:0] BREAK_LAST = LW'(BREAK_CLKS - 1);
  localparam logic [MW-1:0] MAB_MIN    = MW'(MAB_CLKS);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BREAK      = 3'd1,
    ST_MAB        = 3'd2,
    ST_START_CODE = 3'd3,
    ST_SLOTS      = 3'd4,
    ST_WAIT_BREAK = 3'd5
  } state_t;

  function automatic logic [15:0] gamma_entry(input int x);
    real r;
    r = 65535.0 * ((real'(x) / 255.0) ** GAMMA);
    return 16'($rtoi(r + 0.5));
  endfunction

  logic [15:0] lut_s [256];
  for (genvar g = 0; g < 256; g++) begin : g_lut
    localparam logic [15:0] ENTRY = gamma_entry(g);
    assign lut_s[g] = ENTRY;
  end

  logic          sync1_r, line_r, line_prev_r, dmx_tx_r;
  logic [LW-1:0] low_cnt_r;
  logic          fall_s, rise_s, break_s;

  state_t        state_r;
  logic          busy_r;
  logic [3:0]    bit_idx_r;
  logic [BW-1:0] timer_r;
  logic [7:0]    shift_r;
  logic [MW-1:0] mab_cnt_r;
  logic [9:0]    slot_r;
  logic          strobe_r;
  logic [8:0]    channel_r;
  logic [7:0]    data_r;

  logic [15:0]             cnt_r;
  logic [15:0]             pending_r [PWM_CHANNELS];
  logic [15:0]             active_r  [PWM_CHANNELS];
  logic [PWM_CHANNELS-1:0] pwm_r;

  assign fall_s  = line_prev_r & ~line_r;
  assign rise_s  = ~line_prev_r & line_r;
  assign break_s = ~line_r & (low_cnt_r == BREAK_LAST);

  assign dmx_tx = dmx_tx_r;
  assign pwm_n  = ~pwm_r;
  assign oe     = 1'b0;

  // Line synchroniser, repeater register and low-time counter
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r     <= 1'b1;
      line_r      <= 1'b1;
      line_prev_r <= 1'b1;
      dmx_tx_r    <= 1'b1;
      low_cnt_r   <= '0;
    end else begin
      sync1_r     <= dmx_rx;
      line_r      <= sync1_r;
      line_prev_r <= line_r;
      dmx_tx_r    <= dmx_rx;
      if (line_r) begin
        low_cnt_r <= '0;
      end else if (low_cnt_r != BREAK_LAST) begin
        low_cnt_r <= low_cnt_r + LW'(1);
      end
    end
  end

  // Frame FSM with embedded 8N2 byte sampler and slot strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      bit_idx_r <= 4'd0;
      timer_r   <= '0;
      shift_r   <= 8'd0;
      mab_cnt_r <= '0;
      slot_r    <= 10'd0;
      strobe_r  <= 1'b0;
      channel_r <= 9'd0;
      data_r    <= 8'd0;
    end else begin
      strobe_r <= 1'b0;
      if (break_s) begin
        state_r <= ST_BREAK;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_BREAK: begin
            if (rise_s) begin
              state_r   <= ST_MAB;
              mab_cnt_r <= MW'(1);
            end
          end
          ST_MAB: begin
            if (fall_s) begin
              if (mab_cnt_r >= MAB_MIN) begin
                // This falling edge is already the start bit of the start code
                state_r   <= ST_START_CODE;
                busy_r    <= 1'b1;
                bit_idx_r <= 4'd0;
                timer_r   <= HALF_BIT;
              end else begin
                state_r <= ST_IDLE;
              end
            end else if (mab_cnt_r != MAB_MIN) begin
              mab_cnt_r <= mab_cnt_r + MW'(1);
            end
          end
          ST_START_CODE, ST_SLOTS: begin
            if (!busy_r) begin
              if (fall_s) begin
                busy_r    <= 1'b1;
                bit_idx_r <= 4'd0;
                timer_r   <= HALF_BIT;
              end
            end else if (timer_r != '0) begin
              timer_r <= timer_r - BW'(1);
            end else begin
              timer_r   <= FULL_BIT;
              bit_idx_r <= bit_idx_r + 4'd1;
              if (bit_idx_r == 4'd0) begin
                if (line_r) begin
                  busy_r <= 1'b0;
                end
              end else if (bit_idx_r <= 4'd8) begin
                shift_r <= {line_r, shift_r[7:1]};
              end else begin
                busy_r <= 1'b0;
                if (!line_r) begin
                  state_r <= ST_WAIT_BREAK;
                end else if (state_r == ST_START_CODE) begin
                  state_r <= (shift_r == 8'h00) ? ST_SLOTS : ST_WAIT_BREAK;
                  slot_r  <= 10'd0;
                end else if (slot_r != 10'd512) begin
                  strobe_r  <= 1'b1;
                  channel_r <= slot_r[8:0];
                  data_r    <= shift_r;
                  slot_r    <= slot_r + 10'd1;
                end
              end
            end
          end
          ST_IDLE, ST_WAIT_BREAK: begin
            busy_r <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Duty registers, period-boundary transfer and PWM compare
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= 16'd0;
      pwm_r <= '0;
      for (int i = 0; i < PWM_CHANNELS; i++) begin
        pending_r[i] <= 16'd0;
        active_r[i]  <= 16'd0;
      end
    end else begin
      cnt_r <= cnt_r + 16'd1;
      for (int i = 0; i < PWM_CHANNELS; i++) begin
        if (strobe_r && (channel_r == 9'(i))) begin
          pending_r[i] <= lut_s[data_r];
        end
        if (cnt_r == 16'hFFFF) begin
          active_r[i] <= pending_r[i];
        end
        pwm_r[i] <= (cnt_r < active_r[i]);
      end
    end
  end

endmodule

// File: tb/tb_dmx_pwm_dimmer.sv
// Directed-random bench: DMX frames with a spec-level model of slot -> duty,
// checked by per-channel low-time counts in the first PWM period after the update.
module tb_dmx_pwm_dimmer;

  localparam int NCH   = 8;
  localparam int BIT   = 16;
  localparam int BRK   = 352;
  localparam int MAB   = 32;
  localparam int WIN0  = 65537;
  localparam int K     = 3000;

  logic           clock;
  logic           reset;
  logic           dmx_rx;
  logic           dmx_tx;
  logic [NCH-1:0] pwm_n;
  logic           oe;

  dmx_pwm_dimmer #(
    .PWM_CHANNELS(NCH),
    .BIT_CLKS    (BIT),
    .BREAK_CLKS  (BRK),
    .MAB_CLKS    (MAB),
    .GAMMA       (1.8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .dmx_rx(dmx_rx),
    .dmx_tx(dmx_tx),
    .pwm_n (pwm_n),
    .oe    (oe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_cnt = 0;
  int   tx_bad = 0;
  int   oe_bad = 0;
  int   p1_bad = 0;
  int   win_low [NCH];
  logic rx_at_edge = 1'b1;

  int          pend_m [NCH];
  int          snap_m [NCH];
  logic [7:0]  fr_q [$];

  // Clock edges since the last reset edge: equals the PWM counter by definition
  always @(posedge clock) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
    rx_at_edge <= dmx_rx;
  end

  // Continuous monitors for repeater, oe, idle first period and measurement window
  always @(negedge clock) begin
    if (!reset) begin
      if (dmx_tx !== rx_at_edge) tx_bad <= tx_bad + 1;
      if (oe !== 1'b0) oe_bad <= oe_bad + 1;
      if (edge_cnt <= 65536 && pwm_n !== '1) p1_bad <= p1_bad + 1;
      if (edge_cnt >= WIN0 && edge_cnt < WIN0 + K)
        for (int i = 0; i < NCH; i++)
          if (pwm_n[i] === 1'b0) win_low[i] <= win_low[i] + 1;
    end
  end

  function automatic int gamma_ref(input int x);
    real v;
    if (x == 0) return 0;
    v = 65535.0 * $exp(1.8 * $ln(x / 255.0));
    return $rtoi(v + 0.5);
  endfunction

  task automatic check(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic hold(input logic v, input int n);
    dmx_rx = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop1);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
    hold(stop1, BIT);
    hold(1'b1, BIT);
  endtask

  // Only a long-enough break, long-enough MAB and zero start code reach the slots
  task automatic model_frame(input int brk, input int mab, input int sc, input int bad_idx);
    if (brk < BRK || mab < MAB || sc != 0) return;
    for (int i = 0; i < fr_q.size(); i++) begin
      if (i == bad_idx) break;
      if (i < NCH) pend_m[i] = gamma_ref(int'(fr_q[i]));
    end
  endtask

  task automatic send_frame(input int brk, input int mab, input logic [7:0] sc,
                            input int bad_idx, input int glitch_idx);
    hold(1'b0, brk);
    hold(1'b1, mab);
    send_byte(sc, 1'b1);
    for (int i = 0; i < fr_q.size(); i++) begin
      send_byte(fr_q[i], (i == bad_idx) ? 1'b0 : 1'b1);
      if (i == glitch_idx) begin
        hold(1'b0, 3);
        hold(1'b1, 24);
      end
    end
    hold(1'b1, 100);
    model_frame(brk, mab, int'(sc), bad_idx);
  endtask

  function automatic logic [7:0] rnd_small();
    return 8'($urandom_range(44, 2));
  endfunction

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) fr_q.push_back(rnd_small());
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      pend_m[i]  = 0;
      win_low[i] = 0;
    end
    dmx_rx = 1'b1;
    reset  = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_pwm_n", int'(pwm_n), 255);
    check("reset_dmx_tx", int'(dmx_tx), 1);
    check("reset_oe", int'(oe), 0);
    reset = 1'b0;
    hold(1'b1, 200);

    // A: valid frame with a false-start glitch after slot 3
    fr_q = {rnd_small(), rnd_small(), 8'h80, 8'h01};
    push_random(4);
    send_frame(400, 48, 8'h00, -1, 3);

    // B: non-zero start code
    fr_q.delete();
    push_random(8);
    send_frame(400, 48, 8'hCC, -1, -1);

    // C: stop-bit error on slot 2
    fr_q = {rnd_small(), 8'h00, rnd_small()};
    push_random(5);
    send_frame(400, 48, 8'h00, 2, -1);

    // D: break too short
    fr_q.delete();
    push_random(8);
    send_frame(320, 48, 8'h00, -1, -1);

    // E: break of exactly the minimum length
    fr_q = {8'hFF};
    send_frame(BRK, 48, 8'h00, -1, -1);

    // G: mark-after-break too short
    fr_q.delete();
    push_random(3);
    send_frame(BRK, 16, 8'h00, -1, -1);

    snap_m = pend_m;

    // F: valid frame whose write lands just after the period boundary
    while (edge_cnt < 65000) @(negedge clock);
    fr_q = {8'h00};
    send_frame(400, 48, 8'h00, -1, -1);

    while (edge_cnt < WIN0 + K + 2) @(negedge clock);

    for (int i = 0; i < NCH; i++)
      check($sformatf("ch%0d_low_clocks", i), win_low[i], (snap_m[i] < K) ? snap_m[i] : K);
    check("period1_pwm_n_not_idle", p1_bad, 0);
    check("dmx_tx_lag", tx_bad, 0);
    check("oe_enabled", oe_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
